sram_req_arbiter: RTL
=====================

Name: sram_req_arbiter

Overview:
- Two-master to one-slave arbiter for the SRAM-like request protocol (req / wr / size / wstrb / addr / wdata, plus addr_ok / data_ok / rdata).
- Sits between the CPU core's instruction fetch port (m0) and data memory port (m1), and the single SRAM-like port of the AXI bridge (s).
- Grants one request at a time, holds the request stable until it is accepted, and tracks up to MAX_OUTST accepted-but-unanswered transactions.
- Responses return in order; each response is routed back to the master that issued it.

Parameters:
MAX_OUTST, 4, depth of the owner FIFO (number of outstanding accepted transactions); power of two, 2..8
STARVE_LIM, 3, consecutive m1 grants allowed while m0 waits before m0 is forced

Ports:
aclk  input  1  clock
aresetn  input  1  reset; asynchronous assert, active-low
m0_req / m1_req  input  1  master request
m0_wr / m1_wr  input  1  1 = write
m0_size / m1_size  input  2  0 = byte, 1 = half, 2 = word
m0_wstrb / m1_wstrb  input  4  byte strobes
m0_addr / m1_addr  input  32  address
m0_wdata / m1_wdata  input  32  write data
m0_addr_ok / m1_addr_ok  output  1  request accepted
m0_data_ok / m1_data_ok  output  1  response (read data or write done)
m0_rdata / m1_rdata  output  32  read data, valid with data_ok
s_req  output  1  request to bridge
s_wr / s_size / s_wstrb / s_addr / s_wdata  output  1/2/4/32/32  muxed request fields
s_addr_ok  input  1  bridge accepted the request
s_data_ok  input  1  bridge response
s_rdata  input  32  bridge read data
resp_err  output  1  sticky flag: s_data_ok arrived with no outstanding transaction

Behaviour:
- Reset (aresetn low, takes effect immediately):
  - state = IDLE, owner FIFO empty, count = 0, starve_cnt = 0, resp_err = 0.
  - All outputs 0; s_* request fields 0 while s_req = 0.
- Definition: full = (count == MAX_OUTST).
- States: IDLE, HOLD0, HOLD1.
- IDLE:
  - If not full and any req is pending, select a winner combinationally and drive s_req = 1 with the winner's fields in the same cycle (zero-cycle arbitration).
  - Priority: m1 over m0, except that m0 wins when starve_cnt == STARVE_LIM and m0_req = 1.
  - Winner accepted (s_addr_ok = 1) in that cycle: stay in IDLE.
  - Winner not accepted: move to HOLD0 or HOLD1 accordingly.
- HOLDx:
  - s_req = 1 and s_* come from master x only. The grant is locked; the other master cannot preempt.
  - Return to IDLE on the cycle s_addr_ok = 1.
  - If mx_req drops while in HOLDx (protocol violation), deassert s_req and return to IDLE; nothing is pushed.
- Acceptance (s_req & s_addr_ok):
  - Pulse mx_addr_ok = s_addr_ok for the granted master only.
  - Push the owner bit x into the FIFO; count + 1.
- starve_cnt (updated on each acceptance):
  - Increments on an m1 acceptance while m0_req = 1.
  - Resets to 0 on any m0 acceptance, or on an m1 acceptance while m0_req = 0.
  - Saturates at STARVE_LIM.
- Full: s_req stays 0 from IDLE. A grant already in HOLD is never issued while full, because the IDLE check prevents it.
- Response (s_data_ok):
  - Pop the FIFO head h; mh_data_ok = 1 and mh_rdata = s_rdata in the same cycle (combinational route).
  - The other master's rdata is 0.
  - count - 1.
- Simultaneous push and pop: count unchanged, head/tail pointers both advance. A response in the same cycle as acceptance belongs to the older head entry, never to the new one.
- s_data_ok with count = 0: no pop, no master data_ok; set resp_err (cleared only by reset).
- FIFO pointers are log2(MAX_OUTST) bits and wrap modulo MAX_OUTST. count is log2(MAX_OUTST)+1 bits.
- Reset asserted mid-transaction: all state drops immediately. The bridge must be reset alongside; no response replay.

Decomposition:
- Shared package constants:
  - State encodings ST_IDLE = 2'd0, ST_HOLD0 = 2'd1, ST_HOLD1 = 2'd2.
  - Size codes SZ_BYTE / SZ_HALF / SZ_WORD.
  - Owner encodings OWN_INST = 1'b0, OWN_DATA = 1'b1.
- One natural sub-module: sram_owner_fifo, a 1-bit-wide, MAX_OUTST-deep synchronous FIFO with push, pop, head, full, empty and count outputs, and asynchronous active-low reset.

Test Plan:
- Reset released, m0 read at addr 0x1C000000, s_addr_ok = 1 immediately → m0_addr_ok = 1 same cycle. Two cycles later s_data_ok = 1 with s_rdata = 0x02400C00 → m0_data_ok = 1, m0_rdata = 0x02400C00, m1_data_ok = 0.
- m0 and m1 request in the same cycle, s_addr_ok held low 3 cycles → s_addr equals m1_addr throughout HOLD1 and stays locked. m1_addr_ok pulses when s_addr_ok = 1; m0 is granted next.
- m1 requests continuously while m0 waits, with STARVE_LIM = 3 → grants are m1, m1, m1, then m0; starve_cnt returns to 0.
- Issue 4 accepted reads without responses (MAX_OUTST = 4) → s_req = 0 with m0_req = 1. One s_data_ok → the next grant issues the following cycle; owners of the returned data match issue order 0, 1, 1, 0.
- Acceptance and s_data_ok in the same cycle with count = 2 → count stays 2, response routed to the old head owner, new owner appended at the tail.
- s_data_ok with an empty FIFO → no master data_ok and resp_err = 1. Assert aresetn = 0 mid-HOLD1 → s_req = 0 and resp_err = 0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/sram_req_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_req_arbiter_pkg
// Description : Shared constants and types for the two-master SRAM-like
//               request arbiter (state codes, size codes, owner codes).
// Revision    : 1.0 - initial release
// ============================================================================
package sram_req_arbiter_pkg;

  // Arbiter FSM state encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_HOLD0 = 2'd1;
  localparam logic [1:0] ST_HOLD1 = 2'd2;

  // Transfer size codes on the SRAM-like bus
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Owner encodings stored in the outstanding-transaction FIFO
  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  // Request fields forwarded from the winning master to the bridge
  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } sram_req_t;

endpackage
`default_nettype wire

// File: rtl/sram_owner_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sram_owner_fifo
// Description : 1-bit wide synchronous FIFO recording which master owns each
//               accepted-but-unanswered transaction, oldest at the head.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_owner_fifo #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          din,
  input  logic          pop,
  output logic          head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [DEPTH-1:0] r_mem;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // A pop frees a slot in the same cycle, so push is allowed when full only
  // alongside a pop; a pop on an empty FIFO is ignored.
  assign w_do_pop  = pop & (r_count != '0);
  assign w_do_push = push & ((r_count != CW'(DEPTH)) | w_do_pop);

  // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign head  = r_mem[r_rd_ptr];
  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/sram_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_req_arbiter
// Description : Two-master (instruction fetch m0, data m1) to one-slave
//               arbiter for the SRAM-like protocol. Zero-cycle grant from
//               IDLE, grant locked until accepted, in-order response routing
//               through an owner FIFO, m0 anti-starvation.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_req_arbiter
  import sram_req_arbiter_pkg::*;
#(
  parameter int MAX_OUTST  = 4,
  parameter int STARVE_LIM = 3
) (
  input  logic        aclk,
  input  logic        aresetn,
  // master 0 : instruction fetch
  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic [1:0]  m0_size,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_addr_ok,
  output logic        m0_data_ok,
  output logic [31:0] m0_rdata,
  // master 1 : data memory
  input  logic        m1_req,
  input  logic        m1_wr,
  input  logic [1:0]  m1_size,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_addr_ok,
  output logic        m1_data_ok,
  output logic [31:0] m1_rdata,
  // slave : bridge port
  output logic        s_req,
  output logic        s_wr,
  output logic [1:0]  s_size,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic        s_addr_ok,
  input  logic        s_data_ok,
  input  logic [31:0] s_rdata,
  output logic        resp_err
);

  localparam int CW = $clog2(MAX_OUTST) + 1;
  localparam int SW = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
  localparam logic [SW-1:0] c_starve_max = SW'(STARVE_LIM);

  logic [1:0]    r_state;
  logic [1:0]    w_state_next;
  logic [SW-1:0] r_starve_cnt;
  logic          r_resp_err;

  logic          w_grant_valid;
  logic          w_grant_sel;
  logic          w_idle_sel;
  logic          w_accept;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic          w_head;
  logic [CW-1:0] w_count;
  logic          w_unused;
  sram_req_t     w_m0_fields;
  sram_req_t     w_m1_fields;
  sram_req_t     w_s_fields;

  assign w_m0_fields = '{wr: m0_wr, size: m0_size, wstrb: m0_wstrb, addr: m0_addr, wdata: m0_wdata};
  assign w_m1_fields = '{wr: m1_wr, size: m1_size, wstrb: m1_wstrb, addr: m1_addr, wdata: m1_wdata};

  // m1 normally wins; m0 is forced once it has watched STARVE_LIM m1 grants.
  assign w_idle_sel = (m1_req && !((r_starve_cnt == c_starve_max) && m0_req)) ? OWN_DATA : OWN_INST;

  // State register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: lock the grant when the bridge stalls, release on accept or
  // when the locked master withdraws its request.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_valid && !s_addr_ok) begin
          w_state_next = (w_grant_sel == OWN_DATA) ? ST_HOLD1 : ST_HOLD0;
        end
      end
      ST_HOLD0, ST_HOLD1: begin
        if (!w_grant_valid || s_addr_ok) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Grant outputs; everything is held off while reset is asserted.
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant_sel   = OWN_INST;
    case (r_state)
      ST_IDLE: begin
        w_grant_valid = !w_full && (m0_req || m1_req);
        w_grant_sel   = w_idle_sel;
      end
      ST_HOLD0: begin
        w_grant_valid = m0_req;
        w_grant_sel   = OWN_INST;
      end
      ST_HOLD1: begin
        w_grant_valid = m1_req;
        w_grant_sel   = OWN_DATA;
      end
      default: begin
        w_grant_valid = 1'b0;
        w_grant_sel   = OWN_INST;
      end
    endcase
    w_grant_valid = w_grant_valid & aresetn;
  end

  // Request field mux toward the bridge; fields read zero without a request.
  always_comb begin
    w_s_fields = '0;
    if (w_grant_valid) begin
      w_s_fields = (w_grant_sel == OWN_DATA) ? w_m1_fields : w_m0_fields;
    end
  end

  assign s_req   = w_grant_valid;
  assign s_wr    = w_s_fields.wr;
  assign s_size  = w_s_fields.size;
  assign s_wstrb = w_s_fields.wstrb;
  assign s_addr  = w_s_fields.addr;
  assign s_wdata = w_s_fields.wdata;

  assign w_accept   = w_grant_valid & s_addr_ok;
  assign m0_addr_ok = w_accept & (w_grant_sel == OWN_INST);
  assign m1_addr_ok = w_accept & (w_grant_sel == OWN_DATA);

  // Responses pop the oldest owner; the head is read before any same-cycle push.
  assign w_pop      = s_data_ok & ~w_empty & aresetn;
  assign m0_data_ok = w_pop & (w_head == OWN_INST);
  assign m1_data_ok = w_pop & (w_head == OWN_DATA);
  assign m0_rdata   = m0_data_ok ? s_rdata : 32'd0;
  assign m1_rdata   = m1_data_ok ? s_rdata : 32'd0;

  // Anti-starvation counter, updated only on acceptances.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_starve_cnt <= '0;
    end else if (w_accept) begin
      if (w_grant_sel == OWN_DATA && m0_req) begin
        if (r_starve_cnt != c_starve_max) begin
          r_starve_cnt <= r_starve_cnt + SW'(1);
        end
      end else begin
        r_starve_cnt <= '0;
      end
    end
  end

  // Sticky flag for a response that has no outstanding transaction.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_resp_err <= 1'b0;
    end else if (s_data_ok && w_empty) begin
      r_resp_err <= 1'b1;
    end
  end

  assign resp_err = r_resp_err;

  sram_owner_fifo #(
    .DEPTH (MAX_OUTST)
  ) u_owner_fifo (
    .clk   (aclk),
    .rst_n (aresetn),
    .push  (w_accept),
    .din   (w_grant_sel),
    .pop   (w_pop),
    .head  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  // Occupancy is tracked inside the FIFO; full/empty are what the arbiter needs.
  assign w_unused = ^w_count;

endmodule
`default_nettype wire
